fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-domain half of the dual-clock 8-bit FIFO. It sits directly behind the write interface: it consumes wrEn/din, produces fifoFull, and drives the FIFO storage write port. It keeps the binary and Gray write pointers and exports the Gray pointer to the read domain. It synchronises the read-domain Gray pointer and derives the full, almost-full, occupancy and overflow status.

Parameters:
DATA_WIDTH, 8, width of din and memWrData
ADDR_WIDTH, 4, storage address width; DEPTH = 2**ADDR_WIDTH = 16
AF_MARGIN, 2, fifoAlmostFull asserts when occupancy >= DEPTH - AF_MARGIN

Ports:
wrClk  input  1  write-domain clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
wrEn  input  1  write request from producer
din  input  DATA_WIDTH  write data
fifoFull  output  1  FIFO full; writes are dropped while high
fifoAlmostFull  output  1  occupancy >= DEPTH-AF_MARGIN
wrCount  output  ADDR_WIDTH+1  write-side occupancy estimate, 0..DEPTH
overflow  output  1  sticky flag: a write was attempted while full
rdPtrGray  input  ADDR_WIDTH+1  read pointer in Gray code, from read clock domain (asynchronous)
wrPtrGray  output  ADDR_WIDTH+1  registered write pointer in Gray code, to read domain
memWrEn  output  1  storage write strobe
memWrAddr  output  ADDR_WIDTH  storage write address
memWrData  output  DATA_WIDTH  storage write data

Behaviour:
- Clock and reset: one clock, wrClk. rst is asynchronous and active-low: it is asynchronously asserted and is released synchronously by the environment.
- Reset values: wrPtrBin=0, wrPtrGray=0, both synchroniser stages=0, fifoFull=0, fifoAlmostFull=0, wrCount=0, overflow=0.
- Accept rule: accept = wrEn & ~fifoFull.
  - memWrEn = accept, combinational in the same cycle.
  - memWrAddr = wrPtrBin[ADDR_WIDTH-1:0]; memWrData = din; both combinational.
  - Storage captures on the same wrClk edge.
- Pointer update: on accept, wrPtrBin increments by 1 and wraps modulo 2**(ADDR_WIDTH+1).
  - wrPtrGray <= next_bin ^ (next_bin >> 1), registered, so exactly one bit changes per accepted write.
  - Without accept, both pointers hold.
- rdPtrGray synchronisation: two-flop chain (rdSync1, rdSync2) on wrClk; rdSync2 is the only consumer-visible value.
- Full: fifoFull <= (next_gray == {~rdSync2[MSB:MSB-1], rdSync2[MSB-2:0]}), registered.
  - Asserts on the edge that accepts the DEPTH-th outstanding write; visible the following cycle.
- Occupancy: wrCount <= next_bin - gray2bin(rdSync2), ADDR_WIDTH+1 bit modular subtraction, registered.
  - The estimate is pessimistic by the synchroniser latency and never under-reports fill.
- Almost full: fifoAlmostFull <= (occupancy_next >= DEPTH-AF_MARGIN), registered; same timing as wrCount.
- Overflow: wrEn & fifoFull sets overflow on that edge.
  - The write is dropped: memWrEn=0 and the pointer holds.
  - The flag stays set until rst is asserted.
- Read-side release: a change on rdPtrGray is reflected in fifoFull, wrCount and fifoAlmostFull on the 3rd wrClk rising edge after the change (2 sync edges + 1 status edge).
- Simultaneous events: a write and a read release in the same cycle are both applied; occupancy is net-zero, and full stays asserted only if the pointer comparison still matches.
- Reset mid-operation: all state clears immediately and outputs take reset values asynchronously. Storage contents are not cleared; they are treated as invalid.
- gray2bin is a combinational XOR-prefix of rdSync2.

Decomposition:
- Shared package fifo_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - ptr_t = logic [ADDR_WIDTH:0]
  - functions bin2gray and gray2bin, also used by the read-side controller
- Sub-module: sync_2ff, parameterised width, instantiated for rdPtrGray. The read side reuses it for wrPtrGray.

Test Plan:
- Reset: rst=0 with wrEn=1 for 5 cycles -> memWrEn=0, all outputs 0, wrPtrGray=5'b00000; release -> first write has memWrAddr=0.
- Fill: rdPtrGray held 0, 16 writes of din=8'h00..8'h0F -> memWrAddr 0..15 with matching memWrData.
  - fifoAlmostFull first high the cycle after the 14th write.
  - fifoFull=1 and wrCount=16 the cycle after the 16th write.
  - wrPtrGray=5'b11000.
- Overflow: from full, wrEn=1 with din=8'hAA -> memWrEn=0, pointer unchanged, overflow=1; it remains 1 after wrEn drops.
- Release: from full, rdPtrGray 0->5'b00001 -> fifoFull=0 and wrCount=15 after exactly 3 wrClk edges; the next write goes to memWrAddr=0.
- Wrap: 40 writes with rdPtrGray tracking 4 writes behind -> memWrAddr wraps 15->0; wrPtrGray changes exactly one bit per write; fifoFull never asserts.
- Reset mid-fill: after 7 writes, pulse rst low between edges -> outputs clear immediately; the next accepted write uses memWrAddr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for both halves of the dual-clock FIFO.
// Holds the pointer type and the Gray/binary conversion helpers.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    // One extra MSB distinguishes full from empty when the address bits match.
    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[DEF_ADDR_WIDTH] = g[DEF_ADDR_WIDTH];
        for (int i = DEF_ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle: producer handshake, status, pointer exchange and storage port.
interface fifo_wr_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  wrEn;
    logic [DATA_WIDTH-1:0] din;
    logic                  fifoFull;
    logic                  fifoAlmostFull;
    logic [ADDR_WIDTH:0]   wrCount;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   rdPtrGray;
    logic [ADDR_WIDTH:0]   wrPtrGray;
    logic                  memWrEn;
    logic [ADDR_WIDTH-1:0] memWrAddr;
    logic [DATA_WIDTH-1:0] memWrData;

    modport slave (
        input  wrEn, din, rdPtrGray,
        output fifoFull, fifoAlmostFull, wrCount, overflow,
        output wrPtrGray, memWrEn, memWrAddr, memWrData
    );

    modport master (
        output wrEn, din, rdPtrGray,
        input  fifoFull, fifoAlmostFull, wrCount, overflow,
        input  wrPtrGray, memWrEn, memWrAddr, memWrData
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller: pointers, storage write port, and full/almost-full/
// occupancy/overflow status derived from the synchronised read pointer.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_MARGIN  = 2
) (
    input  logic          wrClk,
    input  logic          rst,
    fifo_wr_if.slave      wif
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MSB   = ADDR_WIDTH;

    logic [MSB:0] wrPtrBin_q,  wrPtrBin_d;
    logic [MSB:0] wrPtrGray_q, wrPtrGray_d;
    logic [MSB:0] wrCount_q,   wrCount_d;
    logic         full_q,      full_d;
    logic         almFull_q,   almFull_d;
    logic         overflow_q,  overflow_d;

    logic [MSB:0] rdSync2;
    logic [MSB:0] rdBinSync;
    logic [MSB:0] fullMatch;
    logic         accept;

    sync_2ff #(.WIDTH(MSB + 1)) u_rd_sync (
        .clk_i  (wrClk),
        .rst_ni (rst),
        .d_i    (wif.rdPtrGray),
        .q_o    (rdSync2)
    );

    // Gating with rst keeps the storage strobe quiet while reset is held.
    assign accept = wif.wrEn & ~full_q & rst;

    assign rdBinSync = gray2bin(rdSync2);
    // Full pattern: write pointer one lap ahead, i.e. top two Gray bits inverted.
    assign fullMatch = {~rdSync2[MSB:MSB-1], rdSync2[MSB-2:0]};

    always_comb begin
        wrPtrBin_d  = wrPtrBin_q + {{MSB{1'b0}}, accept};
        wrPtrGray_d = bin2gray(wrPtrBin_d);
        full_d      = (wrPtrGray_d == fullMatch);
        wrCount_d   = wrPtrBin_d - rdBinSync;
        almFull_d   = (int'(wrCount_d) >= DEPTH - AF_MARGIN);
        overflow_d  = overflow_q | (wif.wrEn & full_q);
    end

    always_ff @(posedge wrClk or negedge rst) begin
        if (!rst) begin
            wrPtrBin_q  <= '0;
            wrPtrGray_q <= '0;
            wrCount_q   <= '0;
            full_q      <= 1'b0;
            almFull_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wrPtrBin_q  <= wrPtrBin_d;
            wrPtrGray_q <= wrPtrGray_d;
            wrCount_q   <= wrCount_d;
            full_q      <= full_d;
            almFull_q   <= almFull_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wif.memWrEn        = accept;
    assign wif.memWrAddr      = wrPtrBin_q[MSB-1:0];
    assign wif.memWrData      = wif.din;
    assign wif.wrPtrGray      = wrPtrGray_q;
    assign wif.fifoFull       = full_q;
    assign wif.fifoAlmostFull = almFull_q;
    assign wif.wrCount        = wrCount_q;
    assign wif.overflow       = overflow_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic against an
// integer-counter model of writes, reads and the two-cycle read-pointer delay.
module tb_fifo_wr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    fifo_wr_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) wif ();

    fifo_wr_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
        .wrClk (clk),
        .rst   (rst),
        .wif   (wif)
    );

    always #5 clk = ~clk;

    // Model: total writes accepted, total reads, and the read count as seen
    // one and two write-clock edges later.
    int wrN, rdN, s1, s2, cntM;
    bit fullM, afM, ovfM;

    function automatic logic [4:0] gray(input int b);
        int m;
        m = b & 31;
        return 5'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wrN = 0; rdN = 0; s1 = 0; s2 = 0; cntM = 0;
        fullM = 0; afM = 0; ovfM = 0;
    endtask

    task automatic chk_status(input string ph);
        chk({ph, ".full"},  32'(wif.fifoFull),       32'(fullM));
        chk({ph, ".af"},    32'(wif.fifoAlmostFull), 32'(afM));
        chk({ph, ".count"}, 32'(wif.wrCount),        32'(cntM));
        chk({ph, ".ovf"},   32'(wif.overflow),       32'(ovfM));
        chk({ph, ".gray"},  32'(wif.wrPtrGray),      32'(gray(wrN)));
    endtask

    task automatic step(input string ph, input bit we, input logic [7:0] d);
        bit acc;
        @(negedge clk);
        wif.wrEn = we;
        wif.din = d;
        wif.rdPtrGray = gray(rdN);
        #1;
        acc = we && !fullM;
        chk({ph, ".memWrEn"}, 32'(wif.memWrEn), 32'(acc));
        if (acc) begin
            chk({ph, ".addr"}, 32'(wif.memWrAddr), 32'(wrN % 16));
            chk({ph, ".data"}, 32'(wif.memWrData), 32'(d));
        end
        @(posedge clk);
        if (we && fullM) ovfM = 1;
        if (acc) wrN++;
        cntM = (wrN - s2) % 32;
        fullM = (cntM == 16);
        afM = (cntM >= 14);
        s2 = s1;
        s1 = rdN;
        #1;
        chk_status(ph);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk_status("rstpulse");
        chk("rstpulse.memWrEn", 32'(wif.memWrEn), 32'd0);
        wif.wrEn = 1'b0;
        wif.rdPtrGray = '0;
        #1 rst = 1'b1;
    endtask

    initial begin
        logic [4:0] g_prev;
        model_reset();
        wif.wrEn = 1'b0;
        wif.din = '0;
        wif.rdPtrGray = '0;

        // Reset held with writes requested
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wif.wrEn = 1'b1;
            wif.din = 8'($urandom);
            #1 chk("rst.memWrEn", 32'(wif.memWrEn), 32'd0);
            @(posedge clk);
            #1 chk_status("rst");
        end
        @(negedge clk);
        wif.wrEn = 1'b0;
        rst = 1'b1;

        // Fill with read pointer parked at zero
        for (int i = 0; i < 16; i++) begin
            step("fill", 1'b1, 8'(i));
            chk("fill.af_edge", 32'(wif.fifoAlmostFull), 32'(i + 1 >= 14));
        end
        chk("fill.full16", 32'(wif.fifoFull), 32'd1);
        chk("fill.count16", 32'(wif.wrCount), 32'd16);
        chk("fill.gray16", 32'(wif.wrPtrGray), 32'b11000);

        // Overflow: dropped write, sticky flag
        step("ovf", 1'b1, 8'hAA);
        chk("ovf.flag", 32'(wif.overflow), 32'd1);
        chk("ovf.ptr_hold", 32'(wif.wrPtrGray), 32'b11000);
        step("ovf_idle", 1'b0, 8'h00);
        chk("ovf.sticky", 32'(wif.overflow), 32'd1);

        // Release: one read becomes visible on the third edge
        rdN = 1;
        for (int k = 1; k <= 3; k++) begin
            step("rel", 1'b0, 8'h00);
            chk("rel.full_timing", 32'(wif.fifoFull), 32'(k < 3));
        end
        chk("rel.count15", 32'(wif.wrCount), 32'd15);
        step("rel_wr", 1'b1, 8'h5C);

        // Reset mid-fill
        pulse_reset();
        for (int i = 0; i < 7; i++) step("mid", 1'b1, 8'($urandom));
        pulse_reset();
        step("mid_after", 1'b1, 8'h33);

        // Wrap with reads trailing by four writes
        for (int i = 0; i < 40; i++) begin
            rdN = (wrN > 4) ? wrN - 4 : 0;
            g_prev = wif.wrPtrGray;
            step("wrap", 1'b1, 8'($urandom));
            chk("wrap.onebit", 32'($countones(wif.wrPtrGray ^ g_prev)), 32'd1);
            chk("wrap.nofull", 32'(wif.fifoFull), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if (rdN < wrN && ($urandom_range(2) == 0)) rdN++;
            step("rand", $urandom_range(3) != 0, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
